// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer.
// Holds the op encodings for both families, the controller state
// enumeration and the default width/latency constants.
package muldiv_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_MUL_LAT = 2;

    // Multiply family encodings (muldiv_sel = 0)
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Divide family encodings (muldiv_sel = 1); op[0] = unsigned, op[1] = remainder
    localparam logic [1:0] OP_DIV    = 2'b00;
    localparam logic [1:0] OP_DIVU   = 2'b01;
    localparam logic [1:0] OP_REM    = 2'b10;
    localparam logic [1:0] OP_REMU   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FAST,
        ST_MUL_WAIT,
        ST_DIV_WAIT,
        ST_OUT
    } state_t;

endpackage

// File: rtl/muldiv_fastpath.sv
// Combinational fast-path detector for the multiply/divide sequencer.
// Classifies the incoming operands and decides whether the request can be
// answered without the datapath: divide-by-zero, signed overflow, zero
// operands, or a hit in the last-result cache.
// Ports:
//   a, b, muldiv_sel, op      - incoming request
//   mul_* / div_*             - contents of the multiply and divide cache entries
//   hit                       - request is answered by the fast path
//   value                     - fast-path result (valid when hit)
module muldiv_fastpath
    import muldiv_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int CACHE_EN = 1
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              muldiv_sel,
    input  logic [1:0]        op,
    input  logic              mul_vld,
    input  logic [XLEN-1:0]   mul_a,
    input  logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_full,
    input  logic [1:0]        mul_cop,
    input  logic              div_vld,
    input  logic [XLEN-1:0]   div_a,
    input  logic [XLEN-1:0]   div_b,
    input  logic              div_cop0,
    input  logic [XLEN-1:0]   div_q,
    input  logic [XLEN-1:0]   div_r,
    output logic              hit,
    output logic [XLEN-1:0]   value
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic a_zero;
    logic b_zero;
    logic a_most_neg;
    logic b_ones;
    logic mul_hit;
    logic div_hit;

    assign a_zero     = (a == '0);
    assign b_zero     = (b == '0);
    assign a_most_neg = (a == MOST_NEG);
    assign b_ones     = (b == '1);

    // A cached product serves MUL for any cached op (the low half does not
    // depend on signedness) but the high-half ops only for the same op.
    assign mul_hit = (CACHE_EN != 0) && mul_vld && !muldiv_sel
                     && (a == mul_a) && (b == mul_b)
                     && ((op == OP_MUL) || (op == mul_cop));

    // Quotient and remainder are cached together, so only signedness must match.
    assign div_hit = (CACHE_EN != 0) && div_vld && muldiv_sel
                     && (a == div_a) && (b == div_b) && (op[0] == div_cop0);

    // Priority order matters: divide-by-zero beats overflow beats zero operands
    // beats the cache.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        if (muldiv_sel && b_zero) begin
            hit   = 1'b1;
            value = op[1] ? a : '1;
        end else if (muldiv_sel && !op[0] && a_most_neg && b_ones) begin
            hit   = 1'b1;
            value = op[1] ? '0 : a;
        end else if (a_zero || (!muldiv_sel && b_zero)) begin
            hit   = 1'b1;
            value = '0;
        end else if (mul_hit) begin
            hit   = 1'b1;
            value = (op == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        end else if (div_hit) begin
            hit   = 1'b1;
            value = op[1] ? div_r : div_q;
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Execute-slot sequencer for the M extension. Answers trivial and cached
// requests in one cycle, otherwise drives an external fixed-latency
// multiplier or a handshaked divider and returns the result with a
// one-cycle done pulse. Keeps one cached multiply and one cached divide.
// Ports:
//   clk, reset (async, active-low)
//   start, kill, muldiv_sel, op, a, b        - request / flush
//   opa_q, opb_q, mul_op, mul_prod           - multiplier interface
//   div_start, div_signed, div_rdy,
//   div_quot, div_rem                        - divider interface
//   result, done, busy                       - completion status
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int CACHE_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              kill,
    input  logic              muldiv_sel,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   opa_q,
    output logic [XLEN-1:0]   opb_q,
    output logic [1:0]        mul_op,
    input  logic [2*XLEN-1:0] mul_prod,
    output logic              div_start,
    output logic              div_signed,
    input  logic              div_rdy,
    input  logic [XLEN-1:0]   div_quot,
    input  logic [XLEN-1:0]   div_rem,
    output logic [XLEN-1:0]   result,
    output logic              done,
    output logic              busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               sel_q;
    logic [2*XLEN-1:0]  cap_q;

    logic               cmul_vld;
    logic [XLEN-1:0]    cmul_a;
    logic [XLEN-1:0]    cmul_b;
    logic [2*XLEN-1:0]  cmul_full;
    logic [1:0]         cmul_op;
    logic               cdiv_vld;
    logic [XLEN-1:0]    cdiv_a;
    logic [XLEN-1:0]    cdiv_b;
    logic               cdiv_op0;
    logic [XLEN-1:0]    cdiv_q;
    logic [XLEN-1:0]    cdiv_r;

    logic               fast_hit;
    logic [XLEN-1:0]    fast_value;

    muldiv_fastpath #(
        .XLEN     (XLEN),
        .CACHE_EN (CACHE_EN)
    ) u_fastpath (
        .a          (a),
        .b          (b),
        .muldiv_sel (muldiv_sel),
        .op         (op),
        .mul_vld    (cmul_vld),
        .mul_a      (cmul_a),
        .mul_b      (cmul_b),
        .mul_full   (cmul_full),
        .mul_cop    (cmul_op),
        .div_vld    (cdiv_vld),
        .div_a      (cdiv_a),
        .div_b      (cdiv_b),
        .div_cop0   (cdiv_op0),
        .div_q      (cdiv_q),
        .div_r      (cdiv_r),
        .hit        (fast_hit),
        .value      (fast_value)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // kill overrides everything, including a completion already on its way
    // out, so a flushed instruction never signals done.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        div_start  = (state == ST_DIV_WAIT);
        if (kill) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (fast_hit) begin
                            state_next = ST_FAST;
                        end else if (muldiv_sel) begin
                            state_next = ST_DIV_WAIT;
                        end else begin
                            state_next = ST_MUL_WAIT;
                        end
                    end
                end
                ST_FAST: begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_MUL_WAIT: begin
                    if (cnt == '0) begin
                        state_next = ST_OUT;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_rdy) begin
                        state_next = ST_OUT;
                    end
                end
                ST_OUT: begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Operand latching, result capture and cache update. The raw datapath
    // output is kept in cap_q so the cache can be written in OUT, after the
    // multiplier/divider outputs may already have moved on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_q      <= '0;
            opb_q      <= '0;
            mul_op     <= '0;
            div_signed <= 1'b0;
            result     <= '0;
            cnt        <= '0;
            op_q       <= '0;
            sel_q      <= 1'b0;
            cap_q      <= '0;
            cmul_vld   <= 1'b0;
            cmul_a     <= '0;
            cmul_b     <= '0;
            cmul_full  <= '0;
            cmul_op    <= '0;
            cdiv_vld   <= 1'b0;
            cdiv_a     <= '0;
            cdiv_b     <= '0;
            cdiv_op0   <= 1'b0;
            cdiv_q     <= '0;
            cdiv_r     <= '0;
        end else if (!kill) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (fast_hit) begin
                            result <= fast_value;
                        end else begin
                            opa_q <= a;
                            opb_q <= b;
                            op_q  <= op;
                            sel_q <= muldiv_sel;
                            if (muldiv_sel) begin
                                div_signed <= ~op[0];
                            end else begin
                                mul_op <= op;
                                cnt    <= CNT_LOAD;
                            end
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt == '0) begin
                        result <= (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
                        cap_q  <= mul_prod;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_rdy) begin
                        result <= op_q[1] ? div_rem : div_quot;
                        cap_q  <= {div_rem, div_quot};
                    end
                end
                ST_OUT: begin
                    if (sel_q) begin
                        cdiv_vld <= 1'b1;
                        cdiv_a   <= opa_q;
                        cdiv_b   <= opb_q;
                        cdiv_op0 <= op_q[0];
                        cdiv_q   <= cap_q[XLEN-1:0];
                        cdiv_r   <= cap_q[2*XLEN-1:XLEN];
                    end else begin
                        cmul_vld  <= 1'b1;
                        cmul_a    <= opa_q;
                        cmul_b    <= opb_q;
                        cmul_full <= cap_q;
                        cmul_op   <= op_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: behavioural multiplier and
// divider responders, an architectural reference for every M-extension op
// and a small model of the two-entry result cache to predict latency.
module tb_muldiv_seq_ctrl;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int BOUND   = 64;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic        muldiv_sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [1:0]  mul_op;
    logic [63:0] mul_prod = '0;
    logic        div_start;
    logic        div_signed;
    logic        div_rdy = 1'b0;
    logic [31:0] div_quot = '0;
    logic [31:0] div_rem = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          divDelay = 0;
    int          divCount = 0;
    logic        strayReq = 1'b0;

    // Reference-model state
    bit          mValid = 0;
    logic [31:0] mA = '0;
    logic [31:0] mB = '0;
    logic [1:0]  mOp = '0;
    bit          dValid = 0;
    logic [31:0] dA = '0;
    logic [31:0] dB = '0;
    bit          dOp0 = 0;
    logic [31:0] expRes = '0;
    logic [31:0] expOpa = '0;
    logic [31:0] expOpb = '0;
    logic [1:0]  expMulOp = '0;
    bit          expDivSigned = 0;

    always #5 clk = ~clk;

    muldiv_seq_ctrl #(
        .XLEN     (XLEN),
        .MUL_LAT  (MUL_LAT),
        .CACHE_EN (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kill       (kill),
        .muldiv_sel (muldiv_sel),
        .op         (op),
        .a          (a),
        .b          (b),
        .opa_q      (opa_q),
        .opb_q      (opb_q),
        .mul_op     (mul_op),
        .mul_prod   (mul_prod),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_rdy    (div_rdy),
        .div_quot   (div_quot),
        .div_rem    (div_rem),
        .result     (result),
        .done       (done),
        .busy       (busy)
    );

    // Architectural result of any M-extension op
    function automatic logic [31:0] refCalc(input bit sel, input logic [1:0] o,
                                            input logic [31:0] x, input logic [31:0] y);
        longint          sp;
        longint unsigned up;
        logic [63:0]     w;
        if (!sel) begin
            if (o == 2'b11) begin
                up = 64'(x) * 64'(y);
                w  = up;
            end else if (o == 2'b10) begin
                sp = longint'(int'(x)) * longint'(64'(y));
                w  = sp;
            end else begin
                sp = longint'(int'(x)) * longint'(int'(y));
                w  = sp;
            end
            return (o == 2'b00) ? w[31:0] : w[63:32];
        end
        if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (x == MIN_NEG && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
            return o[1] ? 32'(int'(x) % int'(y)) : 32'(int'(x) / int'(y));
        end
        return o[1] ? (x % y) : (x / y);
    endfunction

    function automatic logic [63:0] mulModel(input logic [31:0] x, input logic [31:0] y,
                                             input logic [1:0] o);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = (o == 2'b11) ? {32'h0, x} : {{32{x[31]}}, x};
        ey = o[1] ? {32'h0, y} : {{32{y[31]}}, y};
        return ex * ey;
    endfunction

    function automatic logic [63:0] divModel(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        q = refCalc(1'b1, {1'b0, ~sgn}, x, y);
        r = refCalc(1'b1, {1'b1, ~sgn}, x, y);
        return {q, r};
    endfunction

    // Whether the request should finish in one cycle
    function automatic bit predictFast(input bit sel, input logic [1:0] o,
                                       input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h0 || y == 32'h0) return 1;
        if (sel && !o[0] && x == MIN_NEG && y == 32'hFFFF_FFFF) return 1;
        if (!sel && mValid && x == mA && y == mB && (o == 2'b00 || o == mOp)) return 1;
        if (sel && dValid && x == dA && y == dB && o[0] == dOp0) return 1;
        return 0;
    endfunction

    // Multiplier: one register stage after opa_q, so the product is ready
    // MUL_LAT cycles after the operands are registered.
    always @(posedge clk) begin
        mul_prod <= mulModel(opa_q, opb_q, mul_op);
    end

    // Divider: answers divDelay cycles after seeing div_start; garbage otherwise.
    always @(posedge clk) begin
        if (strayReq) begin
            div_rdy  <= 1'b1;
            div_quot <= $urandom;
            div_rem  <= $urandom;
            divCount <= 0;
        end else if (div_start && !div_rdy) begin
            if (divCount >= divDelay) begin
                div_rdy               <= 1'b1;
                {div_quot, div_rem}   <= divModel(opa_q, opb_q, div_signed);
                divCount              <= 0;
            end else begin
                div_rdy  <= 1'b0;
                div_quot <= $urandom;
                div_rem  <= $urandom;
                divCount <= divCount + 1;
            end
        end else begin
            div_rdy  <= 1'b0;
            div_quot <= $urandom;
            div_rem  <= $urandom;
            divCount <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One request; optional kill at wait cycle killAt, optional stray start mid-wait
    task automatic applyStimulus(input bit sel, input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input int dly, input int killAt,
                                 input bit intrude);
        bit fast;
        int lat;
        int expLat;
        bit sawDiv;
        fast     = predictFast(sel, o, x, y);
        expLat   = fast ? 1 : (sel ? dly + 3 : MUL_LAT + 1);
        divDelay = dly;
        @(negedge clk);
        start = 1'b1; muldiv_sel = sel; op = o; a = x; b = y;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        sawDiv = 0;
        if (!fast) begin
            expOpa = x;
            expOpb = y;
            if (sel) expDivSigned = ~o[0];
            else     expMulOp = o;
        end
        checkOutput("busy", busy, 1);
        while (!done && lat < BOUND) begin
            if (div_start) sawDiv = 1;
            if (killAt == lat) begin
                kill = 1'b1;
                @(negedge clk);
                kill = 1'b0;
                checkOutput("kill busy", busy, 0);
                checkOutput("kill done", done, 0);
                checkOutput("kill div_start", div_start, 0);
                checkOutput("kill result", result, expRes);
                checkOutput("kill opa_q", opa_q, expOpa);
                @(negedge clk);
                checkOutput("kill no done", done, 0);
                return;
            end
            if (intrude && lat == 2) begin
                start = 1'b1; a = ~x; b = y + 1; op = ~o;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        expRes = refCalc(sel, o, x, y);
        checkOutput("done seen", done, 1);
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("result", result, expRes);
        checkOutput("div_start use", sawDiv, (sel && !fast));
        checkOutput("opa_q", opa_q, expOpa);
        checkOutput("opb_q", opb_q, expOpb);
        checkOutput("mul_op", mul_op, expMulOp);
        checkOutput("div_signed", div_signed, expDivSigned);
        if (!fast) begin
            if (sel) begin
                dValid = 1; dA = x; dB = y; dOp0 = o[0];
            end else begin
                mValid = 1; mA = x; mB = y; mOp = o;
            end
        end
        @(negedge clk);
        checkOutput("done pulse", done, 0);
        checkOutput("idle busy", busy, 0);
    endtask

    // start and kill together in IDLE: request must vanish
    task automatic applyKillStart(input bit sel, input logic [1:0] o,
                                  input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; kill = 1'b1; muldiv_sel = sel; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        checkOutput("killstart busy", busy, 0);
        checkOutput("killstart done", done, 0);
        checkOutput("killstart opa_q", opa_q, expOpa);
        @(negedge clk);
        checkOutput("killstart no done", done, 0);
        checkOutput("killstart result", result, expRes);
    endtask

    // div_rdy while idle must do nothing
    task automatic applyStray();
        @(negedge clk);
        strayReq = 1'b1;
        @(negedge clk);
        strayReq = 1'b0;
        @(negedge clk);
        checkOutput("stray busy", busy, 0);
        checkOutput("stray done", done, 0);
        checkOutput("stray result", result, expRes);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN_NEG;
            4:       return 32'($urandom_range(0, 200));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] prevA;
        logic [31:0] prevB;
        reset = 1'b0; start = 1'b0; kill = 1'b0; muldiv_sel = 1'b0;
        op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset done", done, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset div_start", div_start, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset opa_q", opa_q, 0);
        checkOutput("reset mul_op", mul_op, 0);
        checkOutput("reset div_signed", div_signed, 0);
        reset = 1'b1;

        // divide by zero
        applyStimulus(1, 2'b01, 32'd7, 32'd0, 0, 0, 0);
        checkOutput("divu by zero", result, 32'hFFFF_FFFF);
        applyStimulus(1, 2'b11, 32'd7, 32'd0, 0, 0, 0);
        checkOutput("remu by zero", result, 32'd7);
        // signed overflow
        applyStimulus(1, 2'b00, MIN_NEG, 32'hFFFF_FFFF, 0, 0, 0);
        checkOutput("div overflow", result, MIN_NEG);
        applyStimulus(1, 2'b10, MIN_NEG, 32'hFFFF_FFFF, 0, 0, 0);
        checkOutput("rem overflow", result, 32'h0);
        // MULH then MUL from cache
        applyStimulus(0, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
        applyStimulus(0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
        // slow divide, then cached remainder, then a signedness miss
        applyStimulus(1, 2'b00, 32'd100, 32'd7, 8, 0, 0);
        checkOutput("div 100/7", result, 32'd14);
        applyStimulus(1, 2'b10, 32'd100, 32'd7, 0, 0, 0);
        checkOutput("rem 100/7", result, 32'd2);
        applyStimulus(1, 2'b11, 32'd100, 32'd7, 2, 0, 0);
        checkOutput("remu 100/7", result, 32'd2);
        // kill during MUL_WAIT, then full latency again
        applyStimulus(0, 2'b00, 32'h1111, 32'h2222, 0, 2, 0);
        applyStimulus(0, 2'b00, 32'h1111, 32'h2222, 0, 0, 0);
        // kill with start, start during DIV_WAIT, stray ready
        applyKillStart(0, 2'b11, 32'h55, 32'h66);
        applyStimulus(1, 2'b00, 32'd1000, 32'd3, 6, 0, 1);
        checkOutput("div 1000/3", result, 32'd333);
        applyStray();

        prevA = 32'h1234_5678;
        prevB = 32'h9ABC_DEF0;
        for (int i = 0; i < 200; i++) begin
            bit          sel;
            logic [1:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            int          killAt;
            sel = 1'($urandom_range(0, 1));
            o   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                x = prevA;
                y = prevB;
            end else begin
                x = pickOperand();
                y = pickOperand();
            end
            killAt = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            applyStimulus(sel, o, x, y, $urandom_range(0, 6), killAt,
                          sel && ($urandom_range(0, 4) == 0));
            prevA = x;
            prevB = y;
            if ($urandom_range(0, 15) == 0) applyKillStart(sel, o, x, y);
            if ($urandom_range(0, 15) == 0) applyStray();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
